// File: rtl/bayer_stream_tx_pkg.sv
// Shared definitions for the Bayer frame streamer: FSM encoding,
// pixel packing factor and default frame geometry.
package bayer_stream_tx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        STREAM = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam int PIXELS_PER_WORD = 8;
    localparam int DEFAULT_WIDTH   = 320;
    localparam int DEFAULT_HEIGHT  = 240;

endpackage

// File: rtl/bayer_stream_tx_fifo.sv
// Synchronous 64-bit word FIFO; a push into a full FIFO is dropped
// unless a pop frees a slot in the same cycle.
module sync_word_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [63:0]              data_i,
    input  logic                     pop_i,
    output logic [63:0]              data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_q];

    // Qualify requests against occupancy; pop first so full+pop accepts a push.
    always_comb begin
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/bayer_stream_tx.sv
// Streams one raw Bayer frame from word memory: issues reads, buffers
// the words and unpacks them into one 8-bit pixel per cycle.
module bayer_stream_tx
    import bayer_stream_tx_pkg::*;
#(
    parameter int          width       = DEFAULT_WIDTH,
    parameter int          height      = DEFAULT_HEIGHT,
    parameter int          fifoDepth   = 4,
    parameter logic [31:0] baseAddress = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iStart,
    output logic        oReq,
    output logic [31:0] oRdAddress,
    input  logic        iRdValid,
    input  logic [63:0] iRdData,
    output logic        oNewFrame,
    output logic        oValid,
    output logic [7:0]  oData,
    output logic [31:0] oPixelCnt,
    output logic        oBusy,
    output logic        oDone,
    output logic        oError
);

    localparam int          CW          = $clog2(fifoDepth) + 1;
    localparam logic [31:0] TOTAL_PIX   = 32'(width * height);
    localparam logic [31:0] TOTAL_WORDS = 32'(width * height / PIXELS_PER_WORD);
    localparam logic [31:0] DEPTH       = 32'(fifoDepth);

    state_t        state_q;
    logic [31:0]   words_req_q;
    logic [31:0]   pix_cnt_q;
    logic [CW-1:0] outstanding_q;
    logic [2:0]    byte_idx_q;
    logic          new_frame_q;
    logic          valid_q;
    logic          done_q;
    logic          busy_q;
    logic          error_q;
    logic [7:0]    data_q;

    logic [63:0]   fifo_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    logic          active;
    logic          req;
    logic          rsp_accept;
    logic          rsp_idle;
    logic          rsp_dec;
    logic          emit;
    logic          pop;
    logic          overflow;

    // Request gating, response routing and unpacker handshake.
    always_comb begin
        active     = (state_q == START) || (state_q == STREAM);
        req        = active
                     && (words_req_q < TOTAL_WORDS)
                     && ((32'(outstanding_q) + 32'(fifo_count)) < DEPTH);
        rsp_accept = iRdValid && (state_q != IDLE);
        rsp_idle   = iRdValid && (state_q == IDLE);
        rsp_dec    = rsp_accept && (outstanding_q != '0);
        emit       = (state_q == STREAM) && !fifo_empty
                     && (pix_cnt_q < TOTAL_PIX);
        pop        = emit && (byte_idx_q == 3'd7);
        overflow   = rsp_accept && fifo_full && !pop;
    end

    assign oReq       = req;
    assign oRdAddress = req ? (baseAddress + words_req_q) : 32'd0;
    assign oNewFrame  = new_frame_q;
    assign oValid     = valid_q;
    assign oData      = data_q;
    assign oPixelCnt  = pix_cnt_q;
    assign oBusy      = busy_q;
    assign oDone      = done_q;
    assign oError     = error_q;

    sync_word_fifo #(
        .DEPTH (fifoDepth)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (rsp_accept),
        .data_i  (iRdData),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Read address and in-flight request tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            words_req_q   <= '0;
            outstanding_q <= '0;
        end else begin
            if ((state_q == IDLE) && iStart) begin
                words_req_q <= '0;
            end else if (req) begin
                words_req_q <= words_req_q + 32'd1;
            end
            unique case ({req, rsp_dec})
                2'b10:   outstanding_q <= outstanding_q + CW'(1);
                2'b01:   outstanding_q <= outstanding_q - CW'(1);
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    // Frame FSM with registered outputs and byte unpacker.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            new_frame_q <= 1'b0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
            data_q      <= '0;
            pix_cnt_q   <= '0;
            byte_idx_q  <= '0;
        end else begin
            new_frame_q <= 1'b0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            if (rsp_idle || overflow) begin
                error_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (iStart) begin
                        state_q     <= START;
                        new_frame_q <= 1'b1;
                        busy_q      <= 1'b1;
                        pix_cnt_q   <= '0;
                        byte_idx_q  <= '0;
                    end
                end
                START: begin
                    state_q <= STREAM;
                end
                STREAM: begin
                    if (emit) begin
                        valid_q    <= 1'b1;
                        data_q     <= fifo_data[{byte_idx_q, 3'b000} +: 8];
                        byte_idx_q <= byte_idx_q + 3'd1;
                        pix_cnt_q  <= pix_cnt_q + 32'd1;
                    end
                    if (pix_cnt_q == TOTAL_PIX) begin
                        state_q <= FINISH;
                        done_q  <= 1'b1;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bayer_stream_tx.sv
// Self-checking bench for bayer_stream_tx: latency-programmable memory
// model plus a frame-level pixel reference.
module tb_bayer_stream_tx;

    localparam int          W     = 16;
    localparam int          H     = 2;
    localparam int          D     = 4;
    localparam int          TOTAL = W * H;
    localparam int          WORDS = TOTAL / 8;
    localparam logic [31:0] BASE  = 32'h100;
    localparam int          TMO   = 2000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        iStart = 1'b0;
    logic        oReq;
    logic [31:0] oRdAddress;
    logic        iRdValid = 1'b0;
    logic [63:0] iRdData = 64'd0;
    logic        oNewFrame;
    logic        oValid;
    logic [7:0]  oData;
    logic [31:0] oPixelCnt;
    logic        oBusy;
    logic        oDone;
    logic        oError;

    always #5 clk = ~clk;

    bayer_stream_tx #(
        .width       (W),
        .height      (H),
        .fifoDepth   (D),
        .baseAddress (BASE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .iStart     (iStart),
        .oReq       (oReq),
        .oRdAddress (oRdAddress),
        .iRdValid   (iRdValid),
        .iRdData    (iRdData),
        .oNewFrame  (oNewFrame),
        .oValid     (oValid),
        .oData      (oData),
        .oPixelCnt  (oPixelCnt),
        .oBusy      (oBusy),
        .oDone      (oDone),
        .oError     (oError)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Frame memory and expected pixel i: byte (i mod 8) of word i/8.
    logic [63:0] memw [WORDS];

    function automatic logic [7:0] exp_pixel(input int i);
        logic [63:0] w;
        w = memw[i / 8];
        return w[8 * (i % 8) +: 8];
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model state.
    int          lat_lo = 1;
    int          lat_hi = 1;
    bit          force_rv = 1'b0;
    int          due_q[$];
    logic [31:0] adr_q[$];
    int          last_due = 0;
    int          outst = 0;
    int          max_outst = 0;
    int          freq = 0;

    // In-order memory with per-request latency in [lat_lo, lat_hi].
    always @(negedge clk) begin
        int d;
        logic [31:0] a;
        if (reset) begin
            due_q.delete();
            adr_q.delete();
            last_due = 0;
            outst = 0;
            iRdValid = 1'b0;
            iRdData = 64'd0;
        end else begin
            if (oNewFrame) freq = 0;
            if (oReq) begin
                check("rd_address", oRdAddress, BASE + 32'(freq));
                check("req_bound", 64'(freq < WORDS), 64'd1);
                freq++;
                d = cyc + int'($urandom_range(lat_hi, lat_lo));
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                due_q.push_back(d);
                adr_q.push_back(oRdAddress);
                outst++;
                if (outst > max_outst) max_outst = outst;
            end
            iRdValid = 1'b0;
            iRdData = 64'd0;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                a = adr_q.pop_front();
                void'(due_q.pop_front());
                iRdValid = 1'b1;
                iRdData = memw[a[1:0]];
                outst--;
            end
            if (force_rv) begin
                iRdValid = 1'b1;
                iRdData = 64'hDEAD_BEEF_0000_0001;
            end
        end
    end

    // Pixel monitor against the frame reference.
    int pix_idx = 0;
    int done_cnt = 0;
    int nf_cnt = 0;
    int nf_cyc = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    int done_cyc = 0;

    always @(negedge clk) begin
        if (reset) begin
            pix_idx = 0;
        end else begin
            if (oNewFrame) begin
                pix_idx = 0;
                nf_cnt++;
                nf_cyc = cyc;
                check("valid_in_start", 64'(oValid), 64'd0);
            end
            if (oValid) begin
                if (pix_idx == 0) first_cyc = cyc;
                last_cyc = cyc;
                if (pix_idx < TOTAL)
                    check("pixel", 64'(oData), 64'(exp_pixel(pix_idx)));
                else
                    check("extra_pixel", 64'(pix_idx), 64'(TOTAL - 1));
                check("pixel_cnt", 64'(oPixelCnt), 64'(pix_idx + 1));
                pix_idx++;
            end
            if (oDone) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic fill_mem(input bit rnd);
        for (int i = 0; i < WORDS; i++) begin
            if (rnd) begin
                memw[i] = {$urandom, $urandom};
            end else begin
                for (int j = 0; j < 8; j++) memw[i][8*j +: 8] = 8'(8 * i + j);
            end
        end
    endtask

    task automatic run_frame(input bit mid);
        int n;
        n = 0;
        while (oBusy && n < TMO) begin
            @(negedge clk);
            n++;
        end
        iStart = 1'b1;
        @(negedge clk);
        iStart = 1'b0;
        check("new_frame", 64'(oNewFrame), 64'd1);
        check("busy_start", 64'(oBusy), 64'd1);
        n = 0;
        while (oBusy && n < TMO) begin
            @(negedge clk);
            n++;
            iStart = mid && (n == 10);
        end
        iStart = 1'b0;
        if (n >= TMO) check("frame_timeout", 64'(n), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, 64'(oReq), 64'd0);
        check({tag, "_newframe"}, 64'(oNewFrame), 64'd0);
        check({tag, "_valid"}, 64'(oValid), 64'd0);
        check({tag, "_done"}, 64'(oDone), 64'd0);
        check({tag, "_busy"}, 64'(oBusy), 64'd0);
        check({tag, "_error"}, 64'(oError), 64'd0);
        check({tag, "_data"}, 64'(oData), 64'd0);
        check({tag, "_addr"}, 64'(oRdAddress), 64'd0);
        check({tag, "_pixcnt"}, 64'(oPixelCnt), 64'd0);
    endtask

    typedef struct {
        int lo;
        int hi;
        bit rnd;
        bit mid;
        int exp_done;
        int exp_cnt;
        bit exp_err;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int d0;
        int nf0;
        int n;

        vecs[0] = '{lo: 1, hi: 1, rnd: 1'b0, mid: 1'b0, exp_done: 1, exp_cnt: TOTAL, exp_err: 1'b0};
        vecs[1] = '{lo: 5, hi: 5, rnd: 1'b0, mid: 1'b0, exp_done: 1, exp_cnt: TOTAL, exp_err: 1'b0};
        vecs[2] = '{lo: 1, hi: 6, rnd: 1'b1, mid: 1'b0, exp_done: 1, exp_cnt: TOTAL, exp_err: 1'b0};
        vecs[3] = '{lo: 2, hi: 7, rnd: 1'b1, mid: 1'b1, exp_done: 1, exp_cnt: TOTAL, exp_err: 1'b0};
        vecs[4] = '{lo: 1, hi: 1, rnd: 1'b1, mid: 1'b1, exp_done: 1, exp_cnt: TOTAL, exp_err: 1'b0};

        fill_mem(1'b0);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            lat_lo = vecs[v].lo;
            lat_hi = vecs[v].hi;
            fill_mem(vecs[v].rnd);
            d0 = done_cnt;
            run_frame(vecs[v].mid);
            repeat (4) @(negedge clk);
            check("done_count", 64'(done_cnt - d0), 64'(vecs[v].exp_done));
            check("final_pixcnt", 64'(oPixelCnt), 64'(vecs[v].exp_cnt));
            check("pixels_seen", 64'(pix_idx), 64'(vecs[v].exp_cnt));
            check("error_flag", 64'(oError), 64'(vecs[v].exp_err));
            check("busy_after", 64'(oBusy), 64'd0);
            check("words_req", 64'(freq), 64'(WORDS));
            check("newframe_first", 64'(nf_cyc < first_cyc), 64'd1);
            if (vecs[v].hi == 1) begin
                check("first_latency",
                      64'((first_cyc - nf_cyc >= 1) && (first_cyc - nf_cyc <= 3)), 64'd1);
                check("throughput", 64'(last_cyc - first_cyc), 64'(TOTAL - 1));
                check("frame_time", 64'(done_cyc - nf_cyc <= TOTAL + 5), 64'd1);
            end
        end
        check("max_outstanding", 64'(max_outst <= D), 64'd1);

        // Reset in the middle of a frame.
        lat_lo = 1;
        lat_hi = 3;
        fill_mem(1'b0);
        d0 = done_cnt;
        iStart = 1'b1;
        @(negedge clk);
        iStart = 1'b0;
        n = 0;
        while (pix_idx < 10 && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (n >= TMO) check("midreset_timeout", 64'(n), 64'd0);
        #2 reset = 1'b1;
        #1 check_reset_outputs("async_reset");
        @(negedge clk);
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("no_done_on_abort", 64'(done_cnt - d0), 64'd0);
        d0 = done_cnt;
        run_frame(1'b0);
        repeat (4) @(negedge clk);
        check("restart_done", 64'(done_cnt - d0), 64'd1);
        check("restart_pixcnt", 64'(oPixelCnt), 64'(TOTAL));
        check("restart_pixels", 64'(pix_idx), 64'(TOTAL));

        // Back-to-back frames with address restart.
        lat_lo = 1;
        lat_hi = 1;
        fill_mem(1'b1);
        nf0 = nf_cnt;
        d0 = done_cnt;
        run_frame(1'b0);
        run_frame(1'b0);
        repeat (4) @(negedge clk);
        check("b2b_newframes", 64'(nf_cnt - nf0), 64'd2);
        check("b2b_dones", 64'(done_cnt - d0), 64'd2);
        check("b2b_words", 64'(freq), 64'(WORDS));
        check("b2b_pixcnt", 64'(oPixelCnt), 64'(TOTAL));

        // Spurious response while idle.
        @(posedge clk);
        #1 force_rv = 1'b1;
        @(posedge clk);
        #1 force_rv = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_rsp_error", 64'(oError), 64'd1);
        check("idle_rsp_valid", 64'(oValid), 64'd0);
        check("idle_rsp_nopix", 64'(pix_idx), 64'(TOTAL));
        repeat (10) @(negedge clk);
        check("error_sticky", 64'(oError), 64'd1);
        check("idle_pixcnt_hold", 64'(oPixelCnt), 64'(TOTAL));
        #2 reset = 1'b1;
        #1 check("error_cleared", 64'(oError), 64'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
